// File: rtl/ascon_aead_core.sv
// Ascon-128 / Ascon-128a AEAD engine, one permutation round per cycle.
// Host streams pre-padded AD and data blocks; the final data block is always the 10* pad block.
module ascon_aead_core #(
    parameter int RATE      = 64,
    parameter int BLK_AD_AW = 10,
    parameter int BLK_PT_AW = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 decrypt_i,
    input  logic [127:0]         key_i,
    input  logic [127:0]         nonce_i,
    input  logic [BLK_AD_AW-1:0] ad_size_i,
    input  logic [BLK_PT_AW-1:0] pt_size_i,
    input  logic [RATE-1:0]      din_i,
    input  logic                 din_valid_i,
    output logic                 din_ready_o,
    output logic [RATE-1:0]      dout_o,
    output logic                 dout_valid_o,
    input  logic                 dout_ready_i,
    input  logic [127:0]         tag_i,
    output logic [127:0]         tag_o,
    output logic                 auth_ok_o,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int          B_ROUNDS = (RATE == 128) ? 8 : 6;
    localparam logic [63:0] IV       = (RATE == 128) ? 64'h80800c0800000000 : 64'h80400c0600000000;
    localparam logic [3:0]  RND_LAST = 4'd11;
    localparam logic [3:0]  RND_PB   = 4'(12 - B_ROUNDS);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        INIT    = 4'd1,
        AD_WAIT = 4'd2,
        AD_PERM = 4'd3,
        DSEP    = 4'd4,
        DT_WAIT = 4'd5,
        DT_OUT  = 4'd6,
        DT_PERM = 4'd7,
        FINAL   = 4'd8,
        TAG     = 4'd9
    } state_t;

    state_t               state_reg;
    logic [319:0]         s_reg;
    logic [3:0]           rnd_reg;
    logic                 decrypt_reg;
    logic [BLK_AD_AW-1:0] ad_cnt_reg;
    logic [BLK_PT_AW-1:0] pt_cnt_reg;

    logic [319:0]         round_out;
    logic [319:0]         init_key_mask;
    logic [319:0]         final_key_mask;
    logic [RATE-1:0]      rate_cur;
    logic [127:0]         tag_calc;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // pb reuses the tail of the pa constant schedule, so one index drives both
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128] ^ {56'd0, ~r, r};
        x3 = s[127:64];
        x4 = s[63:0];
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    assign round_out      = ascon_round(s_reg, rnd_reg);
    assign init_key_mask  = {192'd0, key_i};
    assign final_key_mask = {{RATE{1'b0}}, key_i, {(192 - RATE){1'b0}}};
    assign rate_cur       = s_reg[319 -: RATE];
    assign tag_calc       = s_reg[127:0] ^ key_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            s_reg        <= '0;
            rnd_reg      <= '0;
            decrypt_reg  <= 1'b0;
            ad_cnt_reg   <= '0;
            pt_cnt_reg   <= '0;
            din_ready_o  <= 1'b0;
            dout_o       <= '0;
            dout_valid_o <= 1'b0;
            tag_o        <= '0;
            auth_ok_o    <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        s_reg       <= {IV, key_i, nonce_i};
                        decrypt_reg <= decrypt_i;
                        ad_cnt_reg  <= ad_size_i;
                        pt_cnt_reg  <= (pt_size_i == '0) ? BLK_PT_AW'(1) : pt_size_i;
                        rnd_reg     <= '0;
                        tag_o       <= '0;
                        auth_ok_o   <= 1'b0;
                        busy_o      <= 1'b1;
                        state_reg   <= INIT;
                    end
                end
                INIT: begin
                    rnd_reg <= rnd_reg + 4'd1;
                    if (rnd_reg == RND_LAST) begin
                        s_reg <= round_out ^ init_key_mask;
                        if (ad_cnt_reg != '0) begin
                            din_ready_o <= 1'b1;
                            state_reg   <= AD_WAIT;
                        end else begin
                            state_reg <= DSEP;
                        end
                    end else begin
                        s_reg <= round_out;
                    end
                end
                AD_WAIT: begin
                    if (din_valid_i && din_ready_o) begin
                        s_reg[319 -: RATE] <= rate_cur ^ din_i;
                        ad_cnt_reg         <= ad_cnt_reg - BLK_AD_AW'(1);
                        rnd_reg            <= RND_PB;
                        din_ready_o        <= 1'b0;
                        state_reg          <= AD_PERM;
                    end
                end
                AD_PERM: begin
                    s_reg   <= round_out;
                    rnd_reg <= rnd_reg + 4'd1;
                    if (rnd_reg == RND_LAST) begin
                        if (ad_cnt_reg == '0) begin
                            state_reg <= DSEP;
                        end else begin
                            din_ready_o <= 1'b1;
                            state_reg   <= AD_WAIT;
                        end
                    end
                end
                DSEP: begin
                    s_reg       <= s_reg ^ 320'd1;
                    din_ready_o <= 1'b1;
                    state_reg   <= DT_WAIT;
                end
                DT_WAIT: begin
                    if (din_valid_i && din_ready_o) begin
                        dout_o       <= rate_cur ^ din_i;
                        dout_valid_o <= 1'b1;
                        din_ready_o  <= 1'b0;
                        // the pad block is absorbed the same way in both directions
                        if (decrypt_reg && (pt_cnt_reg != BLK_PT_AW'(1)))
                            s_reg[319 -: RATE] <= din_i;
                        else
                            s_reg[319 -: RATE] <= rate_cur ^ din_i;
                        pt_cnt_reg <= pt_cnt_reg - BLK_PT_AW'(1);
                        state_reg  <= DT_OUT;
                    end
                end
                DT_OUT: begin
                    if (dout_ready_i) begin
                        dout_valid_o <= 1'b0;
                        if (pt_cnt_reg == '0) begin
                            s_reg     <= s_reg ^ final_key_mask;
                            rnd_reg   <= '0;
                            state_reg <= FINAL;
                        end else begin
                            rnd_reg   <= RND_PB;
                            state_reg <= DT_PERM;
                        end
                    end
                end
                DT_PERM: begin
                    s_reg   <= round_out;
                    rnd_reg <= rnd_reg + 4'd1;
                    if (rnd_reg == RND_LAST) begin
                        din_ready_o <= 1'b1;
                        state_reg   <= DT_WAIT;
                    end
                end
                FINAL: begin
                    s_reg   <= round_out;
                    rnd_reg <= rnd_reg + 4'd1;
                    if (rnd_reg == RND_LAST)
                        state_reg <= TAG;
                end
                TAG: begin
                    tag_o     <= tag_calc;
                    auth_ok_o <= decrypt_reg && (tag_calc == tag_i);
                    done_o    <= 1'b1;
                    busy_o    <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ascon_aead_core.sv
// Directed bench for ascon_aead_core: official empty-message KATs, encrypt/decrypt round trip,
// output backpressure, start-while-busy and asynchronous reset.
module tb_ascon_aead_core;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sel = 1'b0;
    logic         start = 1'b0;
    logic         decrypt = 1'b0;
    logic [127:0] key = 128'h000102030405060708090a0b0c0d0e0f;
    logic [127:0] nonce = 128'h000102030405060708090a0b0c0d0e0f;
    logic [9:0]   ad_size = '0;
    logic [9:0]   pt_size = '0;
    logic [127:0] din_b = '0;
    logic         din_valid = 1'b0;
    logic         dout_ready = 1'b1;
    logic [127:0] tag_in = '0;

    logic         r64, v64, busy64, done64, ok64;
    logic [63:0]  dout64;
    logic [127:0] tag64;
    logic         r128, v128, busy128, done128, ok128;
    logic [127:0] dout128;
    logic [127:0] tag128;

    logic         start64, start128, dv64, dv128;
    logic         din_ready_m, dout_valid_m, busy_m, done_m, ok_m;
    logic [127:0] dout_m, tag_m;

    int           tests = 0;
    int           fails = 0;
    logic [127:0] ad_blk [4];
    logic [127:0] pt_blk [4];
    logic [127:0] out_blk [4];
    logic [127:0] res_tag;
    logic         res_ok, res_busy;
    int           done_cyc, done_cnt;
    logic [127:0] enc_tag;
    logic [127:0] ct0, ct1;

    localparam logic [127:0] KAT128_TAG = 128'hE355159F292911F794CB1432A0103A8A;
    localparam logic [127:0] KAT128A_TAG = 128'h7A834E6F09210957067B10FD831F0078;
    localparam logic [63:0]  PT0 = 64'h0001020304050607;
    localparam logic [63:0]  PT1 = 64'h08090a0b0c0d0e0f;
    localparam logic [63:0]  PAD64 = 64'h8000000000000000;

    always #5 clk = ~clk;

    assign start64  = start & ~sel;
    assign start128 = start & sel;
    assign dv64     = din_valid & ~sel;
    assign dv128    = din_valid & sel;
    assign din_ready_m  = sel ? r128 : r64;
    assign dout_valid_m = sel ? v128 : v64;
    assign busy_m       = sel ? busy128 : busy64;
    assign done_m       = sel ? done128 : done64;
    assign ok_m         = sel ? ok128 : ok64;
    assign dout_m       = sel ? dout128 : {64'd0, dout64};
    assign tag_m        = sel ? tag128 : tag64;

    ascon_aead_core #(.RATE(64), .BLK_AD_AW(10), .BLK_PT_AW(10)) dut64 (
        .clk_i(clk), .rst_i(rst), .start_i(start64), .decrypt_i(decrypt),
        .key_i(key), .nonce_i(nonce), .ad_size_i(ad_size), .pt_size_i(pt_size),
        .din_i(din_b[63:0]), .din_valid_i(dv64), .din_ready_o(r64),
        .dout_o(dout64), .dout_valid_o(v64), .dout_ready_i(dout_ready),
        .tag_i(tag_in), .tag_o(tag64), .auth_ok_o(ok64), .busy_o(busy64), .done_o(done64)
    );

    ascon_aead_core #(.RATE(128), .BLK_AD_AW(10), .BLK_PT_AW(10)) dut128 (
        .clk_i(clk), .rst_i(rst), .start_i(start128), .decrypt_i(decrypt),
        .key_i(key), .nonce_i(nonce), .ad_size_i(ad_size), .pt_size_i(pt_size),
        .din_i(din_b), .din_valid_i(dv128), .din_ready_o(r128),
        .dout_o(dout128), .dout_valid_o(v128), .dout_ready_i(dout_ready),
        .tag_i(tag_in), .tag_o(tag128), .auth_ok_o(ok128), .busy_o(busy128), .done_o(done128)
    );

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // One operation on the selected core; streams ad_blk then pt_blk, captures dout and result.
    task automatic run_op(input logic s, input logic dec, input int ad_n, input int pt_n,
                          input logic [127:0] tag_exp_in, input int stall_blk,
                          input int stall_len, input int pulse_at);
        int in_idx, out_idx, cyc, st_cnt;
        logic hs_in, hs_out;
        logic [127:0] hold;
        sel = s; decrypt = dec; tag_in = tag_exp_in;
        ad_size = 10'(ad_n); pt_size = 10'(pt_n);
        in_idx = 0; out_idx = 0; st_cnt = 0; hs_in = 0; hs_out = 0; hold = '0;
        done_cyc = 0; done_cnt = 0; res_tag = '0; res_ok = 1'bx; res_busy = 1'bx;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 1;
        while (cyc < 300 && (done_cyc == 0 || cyc < done_cyc + 4)) begin
            if (hs_in) in_idx++;
            if (hs_out) out_idx++;
            start = (cyc == pulse_at);
            din_valid = (in_idx < ad_n + pt_n);
            if (in_idx < ad_n) din_b = ad_blk[in_idx];
            else if (in_idx < ad_n + pt_n) din_b = pt_blk[in_idx - ad_n];
            else din_b = '0;
            dout_ready = 1'b1;
            if (stall_len > 0 && st_cnt == 0 && dout_valid_m && out_idx == stall_blk) begin
                hold = dout_m; dout_ready = 1'b0; st_cnt = 1;
            end else if (st_cnt > 0 && st_cnt < stall_len) begin
                check("stall dout_o", dout_m, hold);
                check("stall dout_valid_o", 128'(dout_valid_m), 128'd1);
                check("stall din_ready_o", 128'(din_ready_m), 128'd0);
                dout_ready = 1'b0; st_cnt++;
            end
            hs_in = din_valid & din_ready_m;
            hs_out = dout_valid_m & dout_ready;
            if (hs_out && out_idx < 4) out_blk[out_idx] = dout_m;
            if (done_m) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = cyc; res_tag = tag_m; res_ok = ok_m; res_busy = busy_m;
                end
            end
            @(negedge clk); cyc++;
        end
        start = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
        check("done seen", 128'(done_cyc != 0), 128'd1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst64 ctl", 128'({r64, v64, busy64, done64, ok64}), 128'd0);
        check("rst64 dout", 128'(dout64), 128'd0);
        check("rst64 tag", tag64, 128'd0);
        check("rst128 ctl", 128'({r128, v128, busy128, done128, ok128}), 128'd0);
        check("rst128 dout", dout128, 128'd0);
        check("rst128 tag", tag128, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Ascon-128 empty message, empty AD
        pt_blk[0] = {64'd0, PAD64};
        run_op(1'b0, 1'b0, 0, 1, '0, 0, 0, 0);
        check("kat128 tag", res_tag, KAT128_TAG);
        check("kat128 latency", 128'(done_cyc), 128'd29);
        check("kat128 done count", 128'(done_cnt), 128'd1);
        check("kat128 busy at done", 128'(res_busy), 128'd0);
        check("kat128 auth_ok enc", 128'(res_ok), 128'd0);
        check("kat128 tag held", tag64, KAT128_TAG);

        // Ascon-128a empty message
        pt_blk[0] = {8'h80, 120'd0};
        run_op(1'b1, 1'b0, 0, 1, '0, 0, 0, 0);
        check("kat128a tag", res_tag, KAT128A_TAG);
        check("kat128a latency", 128'(done_cyc), 128'd29);

        // Same vector, sink stalled 20 cycles on the output block
        run_op(1'b1, 1'b0, 0, 1, '0, 0, 20, 0);
        check("kat128a stall tag", res_tag, KAT128A_TAG);
        check("kat128a stall latency", 128'(done_cyc), 128'd49);

        // 1 AD block + 2 data blocks + pad, encrypt with a mid-message stall
        ad_blk[0] = {64'd0, 64'h0001020304050680};
        pt_blk[0] = {64'd0, PT0};
        pt_blk[1] = {64'd0, PT1};
        pt_blk[2] = {64'd0, PAD64};
        run_op(1'b0, 1'b0, 1, 3, '0, 1, 20, 0);
        check("enc3 latency", 128'(done_cyc), 128'd72);
        check("enc3 auth_ok", 128'(res_ok), 128'd0);
        ct0 = out_blk[0]; ct1 = out_blk[1]; enc_tag = res_tag;

        pt_blk[0] = ct0;
        pt_blk[1] = ct1;
        run_op(1'b0, 1'b1, 1, 3, enc_tag, 0, 0, 0);
        check("dec3 pt0", out_blk[0], {64'd0, PT0});
        check("dec3 pt1", out_blk[1], {64'd0, PT1});
        check("dec3 auth_ok", 128'(res_ok), 128'd1);
        check("dec3 latency", 128'(done_cyc), 128'd52);

        run_op(1'b0, 1'b1, 1, 3, enc_tag ^ 128'd1, 0, 0, 0);
        check("dec3 bad tag pt0", out_blk[0], {64'd0, PT0});
        check("dec3 bad tag auth_ok", 128'(res_ok), 128'd0);

        // start pulsed again while busy must be ignored
        pt_blk[0] = {64'd0, PAD64};
        run_op(1'b0, 1'b0, 0, 1, '0, 0, 0, 10);
        check("busy start tag", res_tag, KAT128_TAG);
        check("busy start latency", 128'(done_cyc), 128'd29);
        check("busy start done count", 128'(done_cnt), 128'd1);

        // reset asserted while absorbing AD
        sel = 1'b0; decrypt = 1'b0; ad_size = 10'd1; pt_size = 10'd1;
        din_b = ad_blk[0]; din_valid = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (14) @(negedge clk);
        check("pre-reset busy", 128'(busy64), 128'd1);
        #2 rst = 1'b1;
        #1;
        check("async rst ctl", 128'({r64, v64, busy64, done64, ok64}), 128'd0);
        check("async rst dout", 128'(dout64), 128'd0);
        check("async rst tag", tag64, 128'd0);
        din_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        pt_blk[0] = {64'd0, PAD64};
        run_op(1'b0, 1'b0, 0, 1, '0, 0, 0, 0);
        check("post-reset tag", res_tag, KAT128_TAG);
        check("post-reset latency", 128'(done_cyc), 128'd29);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
